// File: rtl/maquina_bala_troco_if.sv
// Coin-acceptor / dispenser handshake bundle for the candy vending controller.
// The master side is the coin front end plus dispenser. The slave side is the controller.
interface maquina_bala_troco_if #(
  parameter int VAL_W    = 4,
  parameter int CREDIT_W = 8,
  parameter int COUNT_W  = 16
);
  logic                coin_in;
  logic [VAL_W-1:0]    coin_val;
  logic                cancel;
  logic                ack_in;
  logic                y_out;
  logic                troco_out;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic [COUNT_W-1:0]  vend_count;

  modport master (
    output coin_in, coin_val, cancel, ack_in,
    input  y_out, troco_out, coin_reject, credit, vend_count
  );

  modport slave (
    input  coin_in, coin_val, cancel, ack_in,
    output y_out, troco_out, coin_reject, credit, vend_count
  );
endinterface

// File: rtl/maquina_bala_troco.sv
// Candy vending controller: accumulates coin credit, vends at PRICE and holds the
// request until acknowledged, then pays back excess credit as one-unit change pulses.
module maquina_bala_troco #(
  parameter int VAL_W      = 4,
  parameter int CREDIT_W   = 8,
  parameter int PRICE      = 5,
  parameter int MAX_CREDIT = 20,
  parameter int COUNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  maquina_bala_troco_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [CREDIT_W:0]   MAX_SUM   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   PRICE_SUM = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_CR  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_CR    = CREDIT_W'(1);
  localparam logic [COUNT_W-1:0]  ONE_CNT   = COUNT_W'(1);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                reject_q, reject_d;
  logic [CREDIT_W:0]   sum;
  logic                coin_ok;

  // One guard bit so an oversized coin cannot wrap past MAX_CREDIT unnoticed.
  function automatic logic [CREDIT_W:0] add_coin(input logic [CREDIT_W-1:0] c,
                                                 input logic [VAL_W-1:0]    v);
    return {1'b0, c} + (CREDIT_W+1)'(v);
  endfunction

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    count_d  = count_q;
    reject_d = 1'b0;
    sum      = add_coin(credit_q, bus.coin_val);
    coin_ok  = (bus.coin_val != '0) && (sum <= MAX_SUM);

    case (state_q)
      IDLE, COLLECT: begin
        // Refund takes priority over a simultaneous coin; nothing to refund from IDLE.
        if (state_q == COLLECT && bus.cancel) begin
          state_d  = CHANGE;
          reject_d = bus.coin_in;
        end else if (bus.coin_in) begin
          if (coin_ok) begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = (sum >= PRICE_SUM) ? VEND : COLLECT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      VEND: begin
        reject_d = bus.coin_in;
        if (bus.ack_in) begin
          credit_d = credit_q - PRICE_CR;
          count_d  = count_q + ONE_CNT;
          state_d  = (credit_q == PRICE_CR) ? IDLE : CHANGE;
        end
      end

      CHANGE: begin
        reject_d = bus.coin_in;
        credit_d = credit_q - ONE_CR;
        if (credit_q == ONE_CR) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      count_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      count_q  <= count_d;
      reject_q <= reject_d;
    end
  end

  assign bus.y_out       = (state_q == VEND);
  assign bus.troco_out   = (state_q == CHANGE);
  assign bus.coin_reject = reject_q;
  assign bus.credit      = credit_q;
  assign bus.vend_count  = count_q;

endmodule

// File: tb/tb_maquina_bala_troco.sv
// Directed and randomized checks of the vending controller at three parameter points.
module tb_maquina_bala_troco;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_in = 1'b0;
  logic [3:0] coin_val = '0;
  logic       cancel = 1'b0;
  logic       ack_in = 1'b0;

  int total = 0;
  int bad   = 0;

  maquina_bala_troco_if #(.VAL_W(4), .CREDIT_W(8), .COUNT_W(16)) bus_a ();
  maquina_bala_troco_if #(.VAL_W(4), .CREDIT_W(8), .COUNT_W(16)) bus_b ();
  maquina_bala_troco_if #(.VAL_W(4), .CREDIT_W(8), .COUNT_W(2))  bus_c ();

  assign bus_a.coin_in = coin_in;  assign bus_a.coin_val = coin_val;
  assign bus_a.cancel  = cancel;   assign bus_a.ack_in   = ack_in;
  assign bus_b.coin_in = coin_in;  assign bus_b.coin_val = coin_val;
  assign bus_b.cancel  = cancel;   assign bus_b.ack_in   = ack_in;
  assign bus_c.coin_in = coin_in;  assign bus_c.coin_val = coin_val;
  assign bus_c.cancel  = cancel;   assign bus_c.ack_in   = ack_in;

  maquina_bala_troco #(.VAL_W(4), .CREDIT_W(8), .PRICE(5), .MAX_CREDIT(20), .COUNT_W(16))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  maquina_bala_troco #(.VAL_W(4), .CREDIT_W(8), .PRICE(20), .MAX_CREDIT(20), .COUNT_W(16))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  maquina_bala_troco #(.VAL_W(4), .CREDIT_W(8), .PRICE(5), .MAX_CREDIT(20), .COUNT_W(2))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit c, input int v, input bit cn, input bit a);
    coin_in  = c;
    coin_val = 4'(v);
    cancel   = cn;
    ack_in   = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    coin_in = 0; coin_val = '0; cancel = 0; ack_in = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reference model for dut_a (PRICE 5, MAX 20): credit plus a refunding flag.
  int m_credit, m_count;
  bit m_refund, m_rej;

  task automatic model_step(input bit c, input int v, input bit cn, input bit a);
    m_rej = 0;
    if (m_refund) begin
      m_credit = m_credit - 1;
      if (m_credit == 0) m_refund = 0;
      if (c) m_rej = 1;
    end else if (m_credit >= 5) begin
      if (c) m_rej = 1;
      if (a) begin
        m_credit = m_credit - 5;
        m_count  = (m_count + 1) % 65536;
        m_refund = (m_credit > 0);
      end
    end else if (cn && m_credit > 0) begin
      m_refund = 1;
      if (c) m_rej = 1;
    end else if (c) begin
      if (v != 0 && m_credit + v <= 20) m_credit = m_credit + v;
      else m_rej = 1;
    end
  endtask

  initial begin
    do_reset();
    // Reset state
    chk("rst_credit", 32'(bus_a.credit), 0);
    chk("rst_y", 32'(bus_a.y_out), 0);
    chk("rst_troco", 32'(bus_a.troco_out), 0);
    chk("rst_reject", 32'(bus_a.coin_reject), 0);
    chk("rst_count", 32'(bus_a.vend_count), 0);

    // 1: exact price, delayed ack, no change
    tick(1, 2, 0, 0); chk("t1_credit2", 32'(bus_a.credit), 2); chk("t1_y_a", 32'(bus_a.y_out), 0);
    tick(1, 2, 0, 0); chk("t1_credit4", 32'(bus_a.credit), 4);
    tick(1, 1, 0, 0); chk("t1_credit5", 32'(bus_a.credit), 5); chk("t1_y_hi", 32'(bus_a.y_out), 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0); chk("t1_y_hold", 32'(bus_a.y_out), 1);
    end
    tick(0, 0, 0, 1);
    chk("t1_y_fall", 32'(bus_a.y_out), 0); chk("t1_credit0", 32'(bus_a.credit), 0);
    chk("t1_count", 32'(bus_a.vend_count), 1); chk("t1_troco", 32'(bus_a.troco_out), 0);
    tick(0, 0, 0, 0); chk("t1_troco_after", 32'(bus_a.troco_out), 0);

    // 2: overpay by 2, change train
    tick(1, 3, 0, 0); tick(1, 4, 0, 0);
    chk("t2_credit7", 32'(bus_a.credit), 7); chk("t2_y", 32'(bus_a.y_out), 1);
    tick(0, 0, 0, 1);
    chk("t2_p1", 32'(bus_a.troco_out), 1); chk("t2_cr2", 32'(bus_a.credit), 2);
    chk("t2_count", 32'(bus_a.vend_count), 2); chk("t2_y_lo", 32'(bus_a.y_out), 0);
    tick(0, 0, 0, 0); chk("t2_p2", 32'(bus_a.troco_out), 1); chk("t2_cr1", 32'(bus_a.credit), 1);
    tick(0, 0, 0, 0); chk("t2_end", 32'(bus_a.troco_out), 0); chk("t2_cr0", 32'(bus_a.credit), 0);

    // 3: refund by cancel
    tick(1, 2, 0, 0); chk("t3_credit", 32'(bus_a.credit), 2);
    tick(0, 0, 1, 0); chk("t3_p1", 32'(bus_a.troco_out), 1); chk("t3_y1", 32'(bus_a.y_out), 0);
    tick(0, 0, 0, 0); chk("t3_p2", 32'(bus_a.troco_out), 1); chk("t3_y2", 32'(bus_a.y_out), 0);
    tick(0, 0, 0, 0); chk("t3_end", 32'(bus_a.troco_out), 0); chk("t3_cr0", 32'(bus_a.credit), 0);
    chk("t3_count", 32'(bus_a.vend_count), 2);

    // 5: cancel beats coin, then reset mid change train
    tick(1, 2, 0, 0);
    tick(1, 3, 1, 0);
    chk("t5_reject", 32'(bus_a.coin_reject), 1); chk("t5_p1", 32'(bus_a.troco_out), 1);
    chk("t5_cr2", 32'(bus_a.credit), 2);
    tick(0, 0, 0, 0); chk("t5_rej_lo", 32'(bus_a.coin_reject), 0); chk("t5_p2", 32'(bus_a.troco_out), 1);
    tick(0, 0, 0, 0); chk("t5_end", 32'(bus_a.troco_out), 0);
    tick(1, 9, 0, 0); chk("t5_cr9", 32'(bus_a.credit), 9); chk("t5_y", 32'(bus_a.y_out), 1);
    tick(0, 0, 0, 1); chk("t5_v_p1", 32'(bus_a.troco_out), 1); chk("t5_cr4", 32'(bus_a.credit), 4);
    tick(0, 0, 0, 0); chk("t5_v_p2", 32'(bus_a.troco_out), 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_troco", 32'(bus_a.troco_out), 0); chk("t5_rst_y", 32'(bus_a.y_out), 0);
    chk("t5_rst_cr", 32'(bus_a.credit), 0); chk("t5_rst_cnt", 32'(bus_a.vend_count), 0);
    chk("t5_rst_rej", 32'(bus_a.coin_reject), 0);
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0); chk("t5_no_pulse", 32'(bus_a.troco_out), 0);
    end

    // 4: PRICE = MAX_CREDIT = 20 on dut_b
    tick(1, 15, 0, 0); chk("t4_cr15", 32'(bus_b.credit), 15); chk("t4_rej0", 32'(bus_b.coin_reject), 0);
    tick(1, 8, 0, 0); chk("t4_over_rej", 32'(bus_b.coin_reject), 1); chk("t4_cr_keep", 32'(bus_b.credit), 15);
    tick(1, 5, 0, 0); chk("t4_cr20", 32'(bus_b.credit), 20); chk("t4_y", 32'(bus_b.y_out), 1);
    chk("t4_rej_lo", 32'(bus_b.coin_reject), 0);
    tick(1, 3, 0, 0); chk("t4_vend_rej", 32'(bus_b.coin_reject), 1); chk("t4_vend_cr", 32'(bus_b.credit), 20);
    tick(0, 0, 0, 1); chk("t4_ack_cr", 32'(bus_b.credit), 0); chk("t4_ack_cnt", 32'(bus_b.vend_count), 1);
    chk("t4_ack_troco", 32'(bus_b.troco_out), 0);
    tick(1, 0, 0, 0); chk("t4_zero_rej", 32'(bus_b.coin_reject), 1); chk("t4_zero_cr", 32'(bus_b.credit), 0);
    tick(0, 0, 0, 0);

    // 6: vend counter wrap on dut_c (COUNT_W = 2)
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick(1, 5, 0, 0);
      tick(0, 0, 0, 1);
      chk("t6_wrap", 32'(bus_c.vend_count), 32'(i % 4));
    end

    // Randomized run against the reference model on dut_a
    do_reset();
    m_credit = 0; m_count = 0; m_refund = 0; m_rej = 0;
    for (int i = 0; i < 400; i++) begin
      bit c, cn, a;
      int v;
      c  = ($urandom_range(0, 2) == 0);
      v  = $urandom_range(0, 15);
      a  = ($urandom_range(0, 3) == 0);
      cn = ($urandom_range(0, 9) == 0) && (m_credit > 0);
      model_step(c, v, cn, a);
      tick(c, v, cn, a);
      chk("rnd_credit", 32'(bus_a.credit), 32'(m_credit));
      chk("rnd_y", 32'(bus_a.y_out), 32'(!m_refund && m_credit >= 5));
      chk("rnd_troco", 32'(bus_a.troco_out), 32'(m_refund));
      chk("rnd_reject", 32'(bus_a.coin_reject), 32'(m_rej));
      chk("rnd_count", 32'(bus_a.vend_count), 32'(m_count));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
